// File: rtl/flag_unit.sv
// flag_unit: ALU flag register with condition select; save stack built when FLAG_UNIT_STACK_EN is defined
module flag_unit #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [WIDTH-1:0]           alu_flags,
    input  logic                       _set_flags,
    input  logic                       _do_exec,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       clr_err,
    input  logic [$clog2(WIDTH)-1:0]   cond_sel,
    input  logic                       cond_inv,
    output logic [WIDTH-1:0]           flags,
    output logic                       cond_true,
    output logic [$clog2(DEPTH+1)-1:0] depth_count,
    output logic                       full,
    output logic                       empty,
    output logic                       err_ovf,
    output logic                       err_unf
);
    localparam int SW = $clog2(WIDTH);

    logic             exec;
    logic [WIDTH-1:0] flags_q, flags_d;
    logic [2**SW-1:0] flags_ext;

    assign exec      = ~_do_exec;
    assign flags     = flags_q;
    assign cond_true = flags_ext[cond_sel] ^ cond_inv;

    // zero-extend flags so out-of-range selects read 0 and yield cond_inv
    always_comb begin
        flags_ext              = '0;
        flags_ext[WIDTH-1:0]   = flags_q;
    end

`ifdef FLAG_UNIT_STACK_EN
    localparam int CW = $clog2(DEPTH+1);
    localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] stack_q [DEPTH];
    logic [CW-1:0]    count_q, count_d;
    logic             ovf_q, ovf_d, unf_q, unf_d;
    logic             do_push, do_pop, ok_push, ok_pop, ovf, unf;
    logic [AW-1:0]    widx, ridx;

    assign do_push = exec & push & ~pop;
    assign do_pop  = exec & pop & ~push;
    assign ok_push = do_push & ~full;
    assign ok_pop  = do_pop & ~empty;
    assign ovf     = do_push & full;
    assign unf     = do_pop & empty;
    assign widx    = AW'(count_q);
    assign ridx    = AW'(count_q - CW'(1));

    assign depth_count = count_q;
    assign empty       = count_q == '0;
    assign full        = count_q == CW'(DEPTH);
    assign err_ovf     = ovf_q;
    assign err_unf     = unf_q;

    // pop beats _set_flags; an underflowing pop freezes the flags
    always_comb begin
        flags_d = ok_pop ? stack_q[ridx] : (exec & ~unf & ~_set_flags) ? alu_flags : flags_q;
        count_d = ok_push ? count_q + CW'(1) : ok_pop ? count_q - CW'(1) : count_q;
        ovf_d   = ovf | (ovf_q & ~clr_err);
        unf_d   = unf | (unf_q & ~clr_err);
    end

    // stack storage holds the pre-edge flags; no reset needed since count gates reads
    always_ff @(posedge clk) begin
        if (ok_push) stack_q[widx] <= flags_q;
    end

    // depth counter and sticky error bits
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end
`else
    logic unused_stack_inputs;

    assign unused_stack_inputs = ^{push, pop, clr_err};
    assign depth_count         = '0;
    assign empty               = 1'b1;
    assign full                = 1'b0;
    assign err_ovf             = 1'b0;
    assign err_unf             = 1'b0;

    // without the stack, only an executing set changes the flags
    always_comb begin
        flags_d = (exec & ~_set_flags) ? alu_flags : flags_q;
    end
`endif

    // flag register
    always_ff @(posedge clk) begin
        if (reset) flags_q <= '0;
        else       flags_q <= flags_d;
    end
endmodule

// File: tb/tb_flag_unit.sv
// tb_flag_unit: scoreboard bench for flag_unit, follows FLAG_UNIT_STACK_EN to pick the expected behaviour
module tb_flag_unit;
    localparam int WIDTH = 8;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic [7:0] f;
        logic [2:0] cnt;
        logic       full;
        logic       empty;
        logic       ovf;
        logic       unf;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset, _set_flags, _do_exec, push, pop, clr_err, cond_inv;
    logic [7:0] alu_flags;
    logic [2:0] cond_sel;
    logic [7:0] flags;
    logic       cond_true, full, empty, err_ovf, err_unf;
    logic [2:0] depth_count;

    exp_t       sb[$];
    logic [7:0] m_stk[$];
    logic [7:0] m_flags;
    logic       m_ovf, m_unf;
    int         checks = 0;
    int         errors = 0;
    logic [7:0] pv [4] = '{8'h44, 8'h33, 8'h22, 8'h11};

    flag_unit #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .alu_flags(alu_flags), ._set_flags(_set_flags),
        ._do_exec(_do_exec), .push(push), .pop(pop), .clr_err(clr_err),
        .cond_sel(cond_sel), .cond_inv(cond_inv), .flags(flags), .cond_true(cond_true),
        .depth_count(depth_count), .full(full), .empty(empty),
        .err_ovf(err_ovf), .err_unf(err_unf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic compare();
        exp_t e;
        check("sb_depth", 32'(sb.size()), 1);
        if (sb.size() == 0) return;
        e = sb.pop_front();
        check("flags", flags, e.f);
        check("depth_count", depth_count, e.cnt);
        check("full", full, e.full);
        check("empty", empty, e.empty);
        check("err_ovf", err_ovf, e.ovf);
        check("err_unf", err_unf, e.unf);
        check("cond_true", cond_true, m_flags[cond_sel] ^ cond_inv);
    endtask

    task automatic cyc(input logic rst, ex, set, ps, pp, clr, input logic [7:0] alu);
        logic [7:0] nf;
        logic       e_ovf, e_unf;
        exp_t       e;
        reset = rst; _do_exec = ~ex; _set_flags = ~set;
        push = ps; pop = pp; clr_err = clr; alu_flags = alu;
        nf = m_flags; e_ovf = 1'b0; e_unf = 1'b0;
        if (rst) begin
            nf = 8'h00;
            m_stk.delete();
        end else if (ex) begin
`ifdef FLAG_UNIT_STACK_EN
            if (ps && !pp) begin
                if (m_stk.size() == DEPTH) e_ovf = 1'b1;
                else m_stk.push_back(m_flags);
                if (set) nf = alu;
            end else if (pp && !ps) begin
                if (m_stk.size() == 0) e_unf = 1'b1;
                else nf = m_stk.pop_back();
            end else if (set) nf = alu;
`else
            if (set) nf = alu;
`endif
        end
        m_flags = nf;
        m_ovf = rst ? 1'b0 : (e_ovf | (m_ovf & ~clr));
        m_unf = rst ? 1'b0 : (e_unf | (m_unf & ~clr));
        e.f = m_flags; e.cnt = 3'(m_stk.size());
        e.full = m_stk.size() == DEPTH; e.empty = m_stk.size() == 0;
        e.ovf = m_ovf; e.unf = m_unf;
        sb.push_back(e);
        @(posedge clk);
        #1;
        compare();
    endtask

    initial begin
        m_flags = 8'h00; m_ovf = 1'b0; m_unf = 1'b0;
        cond_sel = 3'd0; cond_inv = 1'b0;
        cyc(1, 0, 0, 0, 0, 0, 8'h5A);
        check("rst_flags", flags, 8'h00);
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        cyc(0, 1, 1, 0, 0, 0, 8'b00111010);
        repeat (3) begin
            cyc(0, 1, 0, 0, 0, 0, 8'hFF);
            check("persist", flags, 8'b00111010);
        end
        cyc(0, 0, 1, 0, 0, 0, 8'hC0);
        check("no_exec", flags, 8'b00111010);
        cyc(0, 1, 1, 0, 0, 0, 8'h80);
        check("exec_load", flags, 8'h80);
        cond_sel = 3'd7; cond_inv = 1'b0; #1;
        check("cond7", cond_true, 1);
        cond_inv = 1'b1; #1;
        check("cond7_inv", cond_true, 0);
        cond_sel = 3'd0; cond_inv = 1'b0; #1;
        check("cond0", cond_true, 0);
        cyc(0, 1, 1, 0, 0, 0, 8'h11);
        cyc(0, 1, 1, 1, 0, 0, 8'h22);
        cyc(0, 1, 1, 1, 0, 0, 8'h33);
        cyc(0, 1, 1, 1, 0, 0, 8'h44);
        cyc(0, 1, 1, 1, 0, 0, 8'h55);
`ifdef FLAG_UNIT_STACK_EN
        check("full4", full, 1);
        check("depth4", depth_count, 4);
        cyc(0, 1, 0, 1, 0, 0, 8'h66);
        check("ovf_set", err_ovf, 1);
        check("depth_ovf", depth_count, 4);
        for (int i = 0; i < 4; i++) begin
            cyc(0, 1, 1, 0, 1, 0, 8'hEE);
            check("pop_val", flags, pv[i]);
        end
        cyc(0, 1, 1, 0, 1, 0, 8'hAA);
        check("unf_hold", flags, 8'h11);
        check("unf_set", err_unf, 1);
        cyc(0, 0, 0, 0, 0, 1, 8'h00);
        check("clr_ovf", err_ovf, 0);
        check("clr_unf", err_unf, 0);
`else
        check("nostk_depth", depth_count, 0);
        check("nostk_empty", empty, 1);
        cyc(0, 1, 0, 1, 0, 0, 8'h66);
        for (int i = 0; i < 4; i++) cyc(0, 1, 1, 0, 1, 0, 8'hEE);
        check("nostk_pop_ignored", flags, 8'hEE);
        check("nostk_ovf", err_ovf, 0);
        check("nostk_unf", err_unf, 0);
        check("nostk_depth_end", depth_count, 0);
`endif
        cyc(0, 1, 1, 0, 0, 0, 8'h01);
        cyc(0, 1, 1, 1, 0, 0, 8'h02);
        cyc(0, 1, 1, 1, 0, 0, 8'h03);
        cyc(1, 1, 1, 1, 0, 0, 8'h77);
        check("rst_mid_flags", flags, 8'h00);
        check("rst_mid_depth", depth_count, 0);
        check("rst_mid_empty", empty, 1);
        repeat (400) begin
            cond_sel = 3'($urandom_range(0, 7));
            cond_inv = 1'($urandom_range(0, 1));
            cyc($urandom_range(0, 49) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 1),
                $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 9) == 0,
                8'($urandom));
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/flag_unit.md
FLAG_UNIT -- requirements
Module: flag_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 8: number of flag bits, ordered czonENGL (bit WIDTH-1 = carry) at default width.
REQ-002 SHALL have parameter DEPTH, default 4: number of flag-save stack entries; legal range 1..16.
REQ-003 SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1: reset, synchronous and active-high.
REQ-005 SHALL have port alu_flags, input, WIDTH: flags from the ALU for the current instruction.
REQ-006 SHALL have port _set_flags, input, 1: active-low request to load alu_flags.
REQ-007 SHALL have port _do_exec, input, 1: active-low "instruction executes"; when high, no state may change.
REQ-008 SHALL have ports push and pop, input, 1 each: save or restore the flag register.
REQ-009 SHALL have port clr_err, input, 1: clears the sticky error bits.
REQ-010 SHALL have ports cond_sel, input, $clog2(WIDTH), and cond_inv, input, 1: the condition flag index and its inversion.
REQ-011 SHALL have port flags, output, WIDTH: the registered flag value.
REQ-012 SHALL have port cond_true, output, 1: flags[cond_sel] XOR cond_inv, combinational.
REQ-013 SHALL have ports depth_count, output, $clog2(DEPTH+1); full, output, 1; and empty, output, 1.
REQ-014 SHALL have ports err_ovf and err_unf, output, 1 each: sticky overflow and underflow indicators.

Function
REQ-015 A cycle "executes" when _do_exec=0; when _do_exec=1, flags, the stack, depth_count and the error bits SHALL hold, whatever the other inputs are.
REQ-016 In an executing cycle with _set_flags=0, pop=0 and no underflow, flags SHALL load alu_flags at the next rising edge (1-cycle latency).
REQ-017 When _set_flags=1, flags SHALL persist across any number of cycles.
REQ-018 An executing push with push=1, pop=0 and not full SHALL write the current (pre-edge) flags to stack[depth_count] and increment depth_count.
REQ-019 If _set_flags=0 in the same push cycle, flags SHALL take alu_flags and the old value SHALL be pushed.
REQ-020 An executing pop with pop=1, push=0 and not empty SHALL load flags from stack[depth_count-1] and decrement depth_count; pop SHALL take priority over _set_flags.
REQ-021 When push=1 and pop=1 together, the stack SHALL be unchanged and _set_flags SHALL apply normally.
REQ-022 A push while full SHALL leave the stack unchanged and set err_ovf; flags SHALL still obey _set_flags.
REQ-023 A pop while empty SHALL leave flags and depth_count unchanged, ignore _set_flags, and set err_unf.
REQ-024 empty SHALL equal (depth_count==0) and full SHALL equal (depth_count==DEPTH), both combinational from the registered count.
REQ-025 clr_err=1 SHALL clear err_ovf and err_unf at the next edge regardless of _do_exec; a new error in the same cycle SHALL win over clr_err.
REQ-026 cond_true SHALL reflect the flags register only, never alu_flags; any cond_sel >= WIDTH SHALL yield cond_true = cond_inv.

Reset
REQ-027 With reset=1 at a rising edge: flags=0, depth_count=0, err_ovf=0, err_unf=0, so empty=1 and full=0.
REQ-028 Reset SHALL override every other input, including mid-push or mid-pop; stack contents need not be cleared.

Configuration
REQ-029 Macro FLAG_UNIT_STACK_EN SHALL control whether the save stack is built in.
REQ-030 With FLAG_UNIT_STACK_EN defined, the stack SHALL be built and behave per REQ-018..REQ-025.
REQ-031 Without FLAG_UNIT_STACK_EN, no stack storage SHALL exist and push/pop SHALL be ignored.
REQ-032 Without FLAG_UNIT_STACK_EN, outputs SHALL be tied: depth_count=0, empty=1, full=0, err_ovf=0, err_unf=0; REQ-016/017 SHALL still apply.

Verification (WIDTH=8, DEPTH=4, macro defined unless stated)
REQ-033 Persistence: reset; exec set with alu_flags=8'b00111010; then 3 exec cycles with _set_flags=1 and alu_flags=8'hFF -> flags stays 8'b00111010 throughout.
REQ-034 Not-executed: _set_flags=0, _do_exec=1, alu_flags=8'hC0 -> flags unchanged; the next cycle with _do_exec=0 and alu_flags=8'h80 -> flags=8'h80.
REQ-035 Stack: push 8'h11, 8'h22, 8'h33, 8'h44 (set+push each cycle) -> full=1, depth_count=4; a 5th push -> err_ovf=1, depth_count=4; 4 pops return 8'h44, 8'h33, 8'h22, 8'h11 per REQ-019 ordering.
REQ-036 Underflow: pop when empty with _set_flags=0 and alu_flags=8'hAA -> flags unchanged, err_unf=1; then clr_err=1 -> both error bits 0.
REQ-037 Condition: flags=8'b10000000, cond_sel=7, cond_inv=0 -> cond_true=1; with cond_inv=1 -> 0; with cond_sel=0 -> 0.
REQ-038 Reset mid-stack with depth_count=2 and push=1 -> flags=0, depth_count=0, empty=1; repeat REQ-035 without the macro -> depth_count=0, empty=1, no errors.
